usb_rx_pkt_ctrl: RTL and testbench

USB_RX_PKT_CTRL -- requirements
Module: usb_rx_pkt_ctrl

---
 rtl/usb_rx_pkt_ctrl_if.sv | 44 ++++
 rtl/usb_rx_pkt_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkt_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_rx_pkt_if : byte/strobe inputs and FIFO/CRC/result outputs of the
//                 USB receive packet controller.   Rev 1.0
// ---------------------------------------------------------------------------
interface usb_rx_pkt_if;
    logic       byte_valid;
    logic [7:0] data_in;
    logic       packet_done;
    logic       crc5_ok;
    logic       crc16_ok;
    logic       fifo_full;

    logic       crc_clear;
    logic       crc5_en;
    logic       crc16_en;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       fifo_commit;
    logic       fifo_discard;
    logic [3:0] pid;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic       token_valid;
    logic       hs_valid;
    logic       data_valid;
    logic       rx_err;
    logic [2:0] err_code;

    modport master (
        output byte_valid, data_in, packet_done, crc5_ok, crc16_ok, fifo_full,
        input  crc_clear, crc5_en, crc16_en, fifo_wr, fifo_wdata, fifo_commit,
               fifo_discard, pid, token_addr, token_endp, token_valid, hs_valid,
               data_valid, rx_err, err_code
    );

    modport slave (
        input  byte_valid, data_in, packet_done, crc5_ok, crc16_ok, fifo_full,
        output crc_clear, crc5_en, crc16_en, fifo_wr, fifo_wdata, fifo_commit,
               fifo_discard, pid, token_addr, token_endp, token_valid, hs_valid,
               data_valid, rx_err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/usb_rx_pkt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_rx_pkt_ctrl : USB RX packet sequencer - PID decode, token/handshake/
//                   data parsing, RX FIFO commit/discard.   Rev 1.0
// ---------------------------------------------------------------------------
module usb_rx_pkt_ctrl #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst,
    usb_rx_pkt_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOKEN = 3'd1,
        S_DATA  = 3'd2,
        S_HSHK  = 3'd3,
        S_DRAIN = 3'd4,
        S_END   = 3'd5
    } state_t;

    localparam logic [2:0]  c_ERR_PID   = 3'd1;
    localparam logic [2:0]  c_ERR_CRC   = 3'd2;
    localparam logic [2:0]  c_ERR_LEN   = 3'd3;
    localparam logic [2:0]  c_ERR_OVF   = 3'd4;
    localparam logic [2:0]  c_ERR_PROTO = 3'd5;
    localparam logic [11:0] c_LEN_LIMIT = 12'(MAX_PAYLOAD + 2);

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [7:0]  r_hold0;
    logic [7:0]  r_hold1;
    logic [2:0]  r_err_rec;
    logic        r_is_data;

    logic        w_byte;
    logic        w_is_tok;
    logic        w_is_dat;
    logic        w_is_hs;
    logic        w_pid_ok;
    logic        w_len_ovf;
    logic [10:0] w_cnt_next;

    always_comb begin
        w_is_tok = 1'b0;
        w_is_dat = 1'b0;
        w_is_hs  = 1'b0;
        case (bus.data_in[3:0])
            4'h1, 4'h5, 4'h9, 4'hD: w_is_tok = 1'b1;
            4'h3, 4'hB:             w_is_dat = 1'b1;
            4'h2, 4'hA, 4'hE:       w_is_hs  = 1'b1;
            default: ;
        endcase
    end

    // A byte arriving together with packet_done is dropped.
    assign w_byte     = bus.byte_valid && !bus.packet_done;
    assign w_pid_ok   = (bus.data_in[7:4] == ~bus.data_in[3:0]) && (w_is_tok || w_is_dat || w_is_hs);
    assign w_cnt_next = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    assign w_len_ovf  = ({1'b0, w_cnt_next} > c_LEN_LIMIT);

    assign bus.crc_clear = !rst && w_byte && (r_state == S_IDLE) && w_pid_ok;
    assign bus.crc5_en   = !rst && w_byte && (r_state == S_TOKEN);
    assign bus.crc16_en  = !rst && w_byte && (r_state == S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 11'd0;
            r_hold0          <= 8'd0;
            r_hold1          <= 8'd0;
            r_err_rec        <= 3'd0;
            r_is_data        <= 1'b0;
            bus.fifo_wr      <= 1'b0;
            bus.fifo_wdata   <= 8'd0;
            bus.fifo_commit  <= 1'b0;
            bus.fifo_discard <= 1'b0;
            bus.pid          <= 4'd0;
            bus.token_addr   <= 7'd0;
            bus.token_endp   <= 4'd0;
            bus.token_valid  <= 1'b0;
            bus.hs_valid     <= 1'b0;
            bus.data_valid   <= 1'b0;
            bus.rx_err       <= 1'b0;
            bus.err_code     <= 3'd0;
        end else begin
            bus.fifo_wr      <= 1'b0;
            bus.fifo_commit  <= 1'b0;
            bus.fifo_discard <= 1'b0;
            bus.token_valid  <= 1'b0;
            bus.hs_valid     <= 1'b0;
            bus.data_valid   <= 1'b0;
            bus.rx_err       <= 1'b0;

            if (bus.packet_done && (r_state != S_IDLE) && (r_state != S_END)) begin
                // Result is registered here so it appears during END.
                r_state <= S_END;
                if (bus.byte_valid) begin
                    bus.rx_err       <= 1'b1;
                    bus.err_code     <= c_ERR_PROTO;
                    bus.fifo_discard <= r_is_data;
                end else begin
                    case (r_state)
                        S_TOKEN: begin
                            if (r_cnt == 11'd2 && bus.crc5_ok) begin
                                bus.token_valid <= 1'b1;
                            end else begin
                                bus.rx_err   <= 1'b1;
                                bus.err_code <= (r_cnt == 11'd2) ? c_ERR_CRC : c_ERR_LEN;
                            end
                        end
                        S_HSHK: bus.hs_valid <= 1'b1;
                        S_DATA: begin
                            if (r_cnt >= 11'd2 && bus.crc16_ok) begin
                                bus.fifo_commit <= 1'b1;
                                bus.data_valid  <= 1'b1;
                            end else begin
                                bus.rx_err       <= 1'b1;
                                bus.fifo_discard <= 1'b1;
                                bus.err_code     <= (r_cnt >= 11'd2) ? c_ERR_CRC : c_ERR_LEN;
                            end
                        end
                        default: begin
                            bus.rx_err       <= 1'b1;
                            bus.err_code     <= r_err_rec;
                            bus.fifo_discard <= r_is_data;
                        end
                    endcase
                end
            end else if (bus.packet_done && bus.byte_valid && (r_state == S_IDLE)) begin
                r_state      <= S_END;
                bus.rx_err   <= 1'b1;
                bus.err_code <= c_ERR_PROTO;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.byte_valid) begin
                            r_cnt     <= 11'd0;
                            r_hold0   <= 8'd0;
                            r_hold1   <= 8'd0;
                            r_is_data <= 1'b0;
                            if (w_pid_ok) begin
                                bus.pid   <= bus.data_in[3:0];
                                r_is_data <= w_is_dat;
                                r_state   <= w_is_tok ? S_TOKEN : (w_is_dat ? S_DATA : S_HSHK);
                            end else begin
                                r_err_rec <= c_ERR_PID;
                                r_state   <= S_DRAIN;
                            end
                        end
                    end
                    S_TOKEN: begin
                        if (bus.byte_valid) begin
                            r_cnt <= w_cnt_next;
                            if (r_cnt == 11'd0) begin
                                bus.token_addr    <= bus.data_in[6:0];
                                bus.token_endp[0] <= bus.data_in[7];
                            end else if (r_cnt == 11'd1) begin
                                bus.token_endp[3:1] <= bus.data_in[2:0];
                            end else begin
                                r_err_rec <= c_ERR_LEN;
                                r_state   <= S_DRAIN;
                            end
                        end
                    end
                    S_HSHK: begin
                        if (bus.byte_valid) begin
                            r_err_rec <= c_ERR_LEN;
                            r_state   <= S_DRAIN;
                        end
                    end
                    S_DATA: begin
                        if (bus.byte_valid) begin
                            r_cnt   <= w_cnt_next;
                            r_hold0 <= bus.data_in;
                            r_hold1 <= r_hold0;
                            // The two most recent bytes may be CRC16; release the older one.
                            if (w_cnt_next >= 11'd3) begin
                                if (w_len_ovf) begin
                                    r_err_rec <= c_ERR_LEN;
                                    r_state   <= S_DRAIN;
                                end else if (bus.fifo_full) begin
                                    r_err_rec <= c_ERR_OVF;
                                    r_state   <= S_DRAIN;
                                end else begin
                                    bus.fifo_wr    <= 1'b1;
                                    bus.fifo_wdata <= r_hold1;
                                end
                            end
                        end
                    end
                    S_END:   r_state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_usb_rx_pkt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_usb_rx_pkt_ctrl : scoreboard bench for usb_rx_pkt_ctrl with a
//                      packet-level reference model.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_usb_rx_pkt_ctrl;
    localparam int MAXP = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_rx_pkt_if bus ();

    usb_rx_pkt_ctrl #(.MAX_PAYLOAD(MAXP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;      // 0 token, 1 handshake, 2 data, 3 error
        logic [2:0] err;
        bit         commit;
        bit         discard;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        int         clr;
        int         c5;
        int         c16;
        int         cyc;
    } res_t;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } wr_t;

    res_t rq[$];
    wr_t  wq[$];

    int checks = 0;
    int errors = 0;
    int n_clr = 0, n_c5 = 0, n_c16 = 0;
    logic [3:0] m_pid = 4'd0;

    logic [3:0] tok_pids [4] = '{4'h1, 4'h5, 4'h9, 4'hD};
    logic [3:0] hs_pids  [3] = '{4'h2, 4'hA, 4'hE};
    logic [3:0] dat_pids [2] = '{4'h3, 4'hB};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pid_type(input logic [7:0] b);
        if (b[7:4] != ~b[3:0]) return 3;
        case (b[3:0])
            4'h1, 4'h5, 4'h9, 4'hD: return 0;
            4'h2, 4'hA, 4'hE:       return 1;
            4'h3, 4'hB:             return 2;
            default:                return 3;
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return {28'd0, bus.crc_clear, bus.crc5_en, bus.crc16_en, bus.fifo_wr, bus.fifo_wdata,
                bus.fifo_commit, bus.fifo_discard, bus.pid, bus.token_addr, bus.token_endp,
                bus.token_valid, bus.hs_valid, bus.data_valid, bus.rx_err, bus.err_code};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a write or a result.
    always @(negedge clk) begin : mon
        res_t r;
        wr_t  w;
        if (rst) begin
            n_clr = 0; n_c5 = 0; n_c16 = 0;
        end else begin
            if (bus.crc_clear) n_clr++;
            if (bus.crc5_en)   n_c5++;
            if (bus.crc16_en)  n_c16++;
            if (bus.fifo_wr) begin
                if (wq.size() == 0) chk("unexpected_fifo_wr", {56'd0, bus.fifo_wdata}, 64'h1FF);
                else begin
                    w = wq.pop_front();
                    chk("fifo_wdata", bus.fifo_wdata, w.d);
                    chk("fifo_wr_cycle", cyc, w.cyc);
                end
            end
            if (bus.token_valid || bus.hs_valid || bus.data_valid || bus.rx_err) begin
                if (rq.size() == 0)
                    chk("unexpected_result", {bus.token_valid, bus.hs_valid, bus.data_valid, bus.rx_err}, 0);
                else begin
                    r = rq.pop_front();
                    chk("result_kind", {bus.token_valid, bus.hs_valid, bus.data_valid, bus.rx_err},
                        4'b1000 >> r.kind);
                    chk("result_cycle", cyc, r.cyc);
                    chk("fifo_commit", bus.fifo_commit, r.commit);
                    chk("fifo_discard", bus.fifo_discard, r.discard);
                    chk("pid", bus.pid, r.pid);
                    if (r.kind == 0) begin
                        chk("token_addr", bus.token_addr, r.addr);
                        chk("token_endp", bus.token_endp, r.endp);
                    end
                    if (r.kind == 3) chk("err_code", bus.err_code, r.err);
                    chk("crc_clear_count", n_clr, r.clr);
                    chk("crc5_en_count", n_c5, r.c5);
                    chk("crc16_en_count", n_c16, r.c16);
                end
                n_clr = 0; n_c5 = 0; n_c16 = 0;
            end else if (bus.fifo_commit || bus.fifo_discard) begin
                chk("unexpected_commit_discard", {bus.fifo_commit, bus.fifo_discard}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of a whole packet, then drive it and queue expectations.
    task automatic send_pkt(input logic [7:0] b[$], input int full_from, input bit c5,
                            input bit c16, input bit ovl, input bit no_done);
        int   n;
        int   typ;
        int   writes;
        int   e;
        bit   wr_at[];
        res_t r;
        wr_t  w;
        n = b.size() - 1;
        typ = pid_type(b[0]);
        wr_at = new[n + 1];
        r = '{default: 0};
        if (typ == 3) begin
            r.kind = 3; r.err = 3'd1;
        end else begin
            m_pid = b[0][3:0];
            r.clr = 1;
            if (typ == 0) begin
                r.c5 = (n > 3) ? 3 : n;
                if (n == 2) begin
                    r.addr = b[1][6:0];
                    r.endp = {b[2][2:0], b[1][7]};
                    if (c5) r.kind = 0;
                    else begin r.kind = 3; r.err = 3'd2; end
                end else begin
                    r.kind = 3; r.err = 3'd3;
                end
            end else if (typ == 1) begin
                if (n == 0) r.kind = 1;
                else begin r.kind = 3; r.err = 3'd3; end
            end else begin
                writes = 0; e = 0; r.c16 = n;
                for (int k = 3; k <= n; k++) begin
                    if (writes == MAXP) begin e = 3; r.c16 = k; break; end
                    if (full_from != 0 && k >= full_from) begin e = 4; r.c16 = k; break; end
                    wr_at[k] = 1'b1;
                    writes++;
                end
                if (e != 0)       begin r.kind = 3; r.err = 3'(e); r.discard = 1; end
                else if (n < 2)   begin r.kind = 3; r.err = 3'd3;  r.discard = 1; end
                else if (c16)     begin r.kind = 2; r.commit = 1; end
                else              begin r.kind = 3; r.err = 3'd2;  r.discard = 1; end
            end
        end
        if (ovl) begin
            r.kind = 3; r.err = 3'd5; r.commit = 0; r.discard = (typ == 2);
        end
        r.pid = m_pid;

        for (int i = 0; i <= n; i++) begin
            bus.byte_valid = 1'b1;
            bus.data_in    = b[i];
            bus.fifo_full  = (full_from != 0 && i >= full_from);
            if (typ == 2 && i >= 3 && wr_at[i]) begin
                w.d = b[i - 2];
                w.cyc = cyc + 1;
                wq.push_back(w);
            end
            tick();
            bus.byte_valid = 1'b0;
            bus.data_in    = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        if (!no_done) begin
            bus.packet_done = 1'b1;
            bus.crc5_ok     = c5;
            bus.crc16_ok    = c16;
            if (ovl) begin
                bus.byte_valid = 1'b1;
                bus.data_in    = 8'($urandom);
            end
            r.cyc = cyc + 1;
            rq.push_back(r);
            tick();
            bus.packet_done = 1'b0;
            bus.byte_valid  = 1'b0;
            bus.crc5_ok     = 1'b0;
            bus.crc16_ok    = 1'b0;
            bus.fifo_full   = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic rand_pkt();
        logic [7:0] b[$];
        logic [7:0] pb;
        logic [3:0] p;
        int t, n, ff;
        t = $urandom_range(0, 3);
        case (t)
            0: begin
                p = tok_pids[$urandom_range(0, 3)];
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 2;
            end
            1: begin
                p = hs_pids[$urandom_range(0, 2)];
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            2: begin
                p = dat_pids[$urandom_range(0, 1)];
                n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXP - 2, MAXP + 5) : $urandom_range(0, 12);
            end
            default: begin
                p = 4'd0;
                n = $urandom_range(0, 4);
            end
        endcase
        if (t == 3) begin
            pb = 8'($urandom);
            while (pid_type(pb) != 3) pb = 8'($urandom);
        end else begin
            pb = {~p, p};
        end
        b.push_back(pb);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        ff = ($urandom_range(0, 4) == 0) ? $urandom_range(3, n + 1) : 0;
        send_pkt(b, ff, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) == 0, 1'b0);
        if ($urandom_range(0, 9) == 0) begin
            bus.packet_done = 1'b1;
            tick();
            bus.packet_done = 1'b0;
            tick();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        bus.byte_valid  = 1'b0;
        bus.data_in     = 8'd0;
        bus.packet_done = 1'b0;
        bus.crc5_ok     = 1'b0;
        bus.crc16_ok    = 1'b0;
        bus.fifo_full   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        q = {8'hE1, 8'h15, 8'hE8};
        send_pkt(q, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        q = {8'hC3, 8'h11, 8'h22, 8'h33, 8'hC0, 8'hC1};
        send_pkt(q, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_pkt(q, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        q = {8'hD3, 8'h01, 8'h02, 8'h03};
        send_pkt(q, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        q = {8'hC3};
        for (int i = 0; i < MAXP + 3; i++) q.push_back(8'($urandom));
        send_pkt(q, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        q = {8'hC3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        send_pkt(q, 4, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a DATA packet.
        q = {8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(q, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        rst = 1'b1;
        m_pid = 4'd0;
        @(negedge clk);
        chk("mid_packet_reset_outputs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("scoreboard_empty_after_reset", rq.size() + wq.size(), 0);
        q = {8'hD2};
        send_pkt(q, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (300) rand_pkt();

        for (int i = 0; i < 50 && (rq.size() + wq.size()) != 0; i++) tick();
        chk("scoreboard_drained", rq.size() + wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
